// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the fetch unit and its helpers.
//   - opcode constants seen by the fetch path
//   - NOP_WORD: IR contents while no instruction is held
//   - fetch_state_t: fetch sequencer states
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;  // JR lives here when jump=1
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_STALL = 6'b000110;
  localparam logic [5:0] OP_NOP   = 6'b111111;

  localparam logic [31:0] NOP_WORD = 32'hFC00_0000;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory req/ack read channel.
//   imem_req   : fetch request, held until imem_ack
//   imem_addr  : fetch address, stable while imem_req is high
//   imem_ack   : read data valid this cycle
//   imem_rdata : instruction word
// master = fetch unit, slave = instruction memory.
interface fetch_unit_if #(
  parameter int ADDR_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;

  modport master (output imem_req, imem_addr, input  imem_ack, imem_rdata);
  modport slave  (input  imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/fetch_unit_next_pc.sv
// next_pc_calc: combinational next-PC selection for the fetch unit.
//   i_pc, i_ir          : current PC and instruction register
//   i_jump, i_beq, i_bne: decoder control
//   i_zero              : ALU zero flag
//   i_rs_data           : JR target
//   o_next_pc           : selected next PC (jump > branch > sequential)
//   o_misalign          : pulse, JR target had nonzero low bits
module next_pc_calc #(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] i_pc,
  input  logic [31:0]       i_ir,
  input  logic              i_jump,
  input  logic              i_beq,
  input  logic              i_bne,
  input  logic              i_zero,
  input  logic [ADDR_W-1:0] i_rs_data,
  output logic [ADDR_W-1:0] o_next_pc,
  output logic              o_misalign
);
  import cpu_pkg::*;

  logic [ADDR_W-1:0] w_pc4, w_jr, w_jtgt, w_boff;
  logic              w_taken;

  assign w_pc4  = i_pc + ADDR_W'(4);
  assign w_jr   = {i_rs_data[ADDR_W-1:2], 2'b00};
  // J/JAL keep the region bits [ADDR_W-1:28] of pc+4; masking rather than
  // slicing keeps this legal at the minimum width of 28.
  assign w_jtgt = (w_pc4 & ~ADDR_W'(28'hFFF_FFFF)) | ADDR_W'({i_ir[25:0], 2'b00});
  assign w_boff = {{(ADDR_W-18){i_ir[15]}}, i_ir[15:0], 2'b00};
  assign w_taken = (i_beq & i_zero) | (i_bne & ~i_zero);

  always_comb begin
    o_next_pc  = w_pc4;
    o_misalign = 1'b0;
    if (i_jump) begin
      if (i_ir[31:26] == OP_RTYPE) begin
        o_next_pc  = w_jr;
        o_misalign = |i_rs_data[1:0];
      end else begin
        o_next_pc  = w_jtgt;
      end
    end else if (w_taken) begin
      o_next_pc = w_pc4 + w_boff;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC sequencer and instruction register feeding the decoder.
//   clk, rst       : clock, synchronous active-low reset
//   imem           : req/ack instruction memory channel (master side)
//   inc_pc, jump, branch_on_eq, branch_on_neq, zero, rs_data : next-PC inputs
//   instr/opcode/funct : IR and its decoder fields
//   pc, pc_plus4   : address of IR instruction and its link value
//   instr_valid    : IR holds a fetched instruction
//   misalign       : sticky, a JR target was not word aligned
module fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [31:0]       NOP_WORD = cpu_pkg::NOP_WORD
) (
  input  logic               clk,
  input  logic               rst,
  fetch_unit_if.master       imem,
  input  logic               inc_pc,
  input  logic               jump,
  input  logic               branch_on_eq,
  input  logic               branch_on_neq,
  input  logic               zero,
  input  logic [ADDR_W-1:0]  rs_data,
  output logic [31:0]        instr,
  output logic [5:0]         opcode,
  output logic [5:0]         funct,
  output logic [ADDR_W-1:0]  pc,
  output logic [ADDR_W-1:0]  pc_plus4,
  output logic               instr_valid,
  output logic               misalign
);
  import cpu_pkg::*;

  fetch_state_t      r_state;
  logic [1:0]        r_idle_cnt;
  logic [ADDR_W-1:0] r_pc;
  logic [31:0]       r_ir;
  logic              r_req, r_valid, r_mis;
  logic [ADDR_W-1:0] w_next_pc;
  logic              w_mis;

  next_pc_calc #(.ADDR_W(ADDR_W)) u_next_pc (
    .i_pc      (r_pc),
    .i_ir      (r_ir),
    .i_jump    (jump),
    .i_beq     (branch_on_eq),
    .i_bne     (branch_on_neq),
    .i_zero    (zero),
    .i_rs_data (rs_data),
    .o_next_pc (w_next_pc),
    .o_misalign(w_mis)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_idle_cnt <= 2'd0;
      r_pc       <= RESET_PC;
      r_ir       <= NOP_WORD;
      r_req      <= 1'b0;
      r_valid    <= 1'b0;
      r_mis      <= 1'b0;
    end else begin
      case (r_state)
        // The release edge plus one full IDLE cycle pass before the
        // request goes out, so it rises two edges after release.
        IDLE: begin
          if (r_idle_cnt == 2'd2) begin
            r_state <= FETCH;
            r_req   <= 1'b1;
          end else begin
            r_idle_cnt <= r_idle_cnt + 2'd1;
          end
        end
        FETCH: begin
          if (imem.imem_ack) begin
            r_ir    <= imem.imem_rdata;
            r_req   <= 1'b0;
            r_valid <= 1'b1;
            r_state <= HOLD;
          end
        end
        HOLD: begin
          // A stall opcode pins the instruction regardless of inc_pc.
          if (inc_pc && (r_ir[31:26] != OP_STALL)) begin
            r_pc    <= w_next_pc;
            r_ir    <= NOP_WORD;
            r_valid <= 1'b0;
            r_req   <= 1'b1;
            r_state <= FETCH;
            if (w_mis) r_mis <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign imem.imem_req  = r_req;
  assign imem.imem_addr = r_pc;
  assign instr       = r_ir;
  assign opcode      = r_ir[31:26];
  assign funct       = r_ir[5:0];
  assign pc          = r_pc;
  assign pc_plus4    = r_pc + ADDR_W'(4);
  assign instr_valid = r_valid;
  assign misalign    = r_mis;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed program walk plus random traffic, all
// outputs compared each cycle against a sequence-level model.
module tb_fetch_unit;
  import cpu_pkg::*;

  localparam int          AW  = 32;
  localparam logic [31:0] RPC = 32'h0;
  localparam logic [31:0] NOP = 32'hFC00_0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if #(.ADDR_W(AW)) imem ();
  logic        inc_pc = 0, jump = 0, beq = 0, bne = 0, zero = 0;
  logic [31:0] rs_data = '0;
  logic [31:0] instr, pc, pc_plus4;
  logic [5:0]  opcode, funct;
  logic        instr_valid, misalign;

  fetch_unit #(.ADDR_W(AW), .RESET_PC(RPC), .NOP_WORD(NOP)) dut (
    .clk(clk), .rst(rst), .imem(imem),
    .inc_pc(inc_pc), .jump(jump), .branch_on_eq(beq), .branch_on_neq(bne),
    .zero(zero), .rs_data(rs_data),
    .instr(instr), .opcode(opcode), .funct(funct), .pc(pc), .pc_plus4(pc_plus4),
    .instr_valid(instr_valid), .misalign(misalign)
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- memory responder ----------------
  bit          rand_mode = 0;
  logic [31:0] dir_word  = '0;
  int          dir_wait  = 0;
  int          seen = 0, rwait = 0;

  function automatic logic [31:0] gen_word();
    logic [5:0]  ops [8] = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd5, 6'd8, 6'd35, 6'd63};
    logic [31:0] r = $urandom;
    logic [5:0]  op = ops[$urandom_range(0, 7)];
    if ($urandom_range(0, 49) == 0) op = 6'd6;
    return {op, r[25:0]};
  endfunction

  initial begin
    imem.imem_ack   = 1'b0;
    imem.imem_rdata = '0;
  end

  always @(negedge clk) begin
    if (imem.imem_req) begin
      if (seen >= (rand_mode ? rwait : dir_wait)) begin
        imem.imem_ack   = 1'b1;
        imem.imem_rdata = rand_mode ? gen_word() : dir_word;
        seen  = 0;
        rwait = $urandom_range(0, 3);
      end else begin
        imem.imem_ack   = 1'b0;
        imem.imem_rdata = $urandom;
        seen++;
      end
    end else begin
      seen = 0;
      imem.imem_ack   = rand_mode ? ($urandom_range(0, 7) == 0) : 1'b0;
      imem.imem_rdata = $urandom;
    end
  end

  // ---------------- behavioural model ----------------
  // Tracks the fetch sequence as "booting / waiting for a word / holding a
  // word" and derives the next PC arithmetically from the rules.
  logic [31:0] m_pc, m_ir;
  bit          m_req, m_valid, m_mis, m_init = 0;
  int          m_boot;

  always @(posedge clk) begin
    logic [31:0] p4, nxt;
    if (!rst) begin
      m_pc = RPC; m_ir = NOP; m_req = 0; m_valid = 0; m_mis = 0;
      m_boot = 0; m_init = 1;
    end else if (m_boot < 2) begin
      m_boot++;
    end else if (m_boot == 2) begin
      m_boot = 3; m_req = 1;
    end else if (m_req) begin
      if (imem.imem_ack) begin
        m_ir = imem.imem_rdata; m_req = 0; m_valid = 1;
      end
    end else if (m_valid && inc_pc && m_ir[31:26] != 6'd6) begin
      p4 = m_pc + 32'd4;
      if (jump && m_ir[31:26] == 6'd0) begin
        nxt = rs_data & ~32'd3;
        if (rs_data[1:0] != 2'd0) m_mis = 1;
      end else if (jump) begin
        nxt = (p4 & 32'hF000_0000) | ({6'd0, m_ir[25:0]} * 32'd4);
      end else if ((beq && zero) || (bne && !zero)) begin
        nxt = p4 + 32'($signed(m_ir[15:0])) * 32'd4;
      end else begin
        nxt = p4;
      end
      m_pc = nxt; m_ir = NOP; m_valid = 0; m_req = 1;
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("imem_req", imem.imem_req, m_req);
      if (m_req) chk("imem_addr", imem.imem_addr, m_pc);
      chk("instr", instr, m_ir);
      chk("opcode", opcode, m_ir[31:26]);
      chk("funct", funct, m_ir[5:0]);
      chk("pc", pc, m_pc);
      chk("pc_plus4", pc_plus4, m_pc + 32'd4);
      chk("instr_valid", instr_valid, m_valid);
      chk("misalign", misalign, m_mis);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name);
    for (int k = 0; k < 20; k++) begin
      if (instr_valid) break;
      tick();
    end
    chk({name, "_valid_timeout"}, instr_valid, 1'b1);
  endtask

  // From HOLD: pulse inc_pc with given controls, check the new fetch
  // address, and wait for the next word (nword) to land.
  task automatic adv(input logic [31:0] nword, input bit j, input bit eq, input bit ne,
                     input bit z, input logic [31:0] rs, input logic [31:0] exp_addr,
                     input string name);
    dir_word = nword; dir_wait = 0;
    jump = j; beq = eq; bne = ne; zero = z; rs_data = rs; inc_pc = 1;
    tick();
    inc_pc = 0; jump = 0; beq = 0; bne = 0;
    chk({name, "_req"}, imem.imem_req, 1'b1);
    chk({name, "_addr"}, imem.imem_addr, exp_addr);
    wait_valid(name);
  endtask

  localparam logic [31:0] W_ADDI = 32'h2001_0005;
  localparam logic [31:0] W_J10  = 32'h0800_0010;  // J target 0x10 -> 0x40
  localparam logic [31:0] W_BEQ  = 32'h1000_FFFE;  // offset -2 words
  localparam logic [31:0] W_JR   = 32'h0020_0008;
  localparam logic [31:0] W_STL  = 32'h1800_0000;

  initial begin
    dir_word = W_ADDI; dir_wait = 0;
    repeat (3) tick();
    chk("rst_req", imem.imem_req, 1'b0);
    chk("rst_instr", instr, 32'hFC00_0000);
    chk("rst_pc", pc, 32'h0);
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_mis", misalign, 1'b0);

    // first request two edges after release, zero-wait ack
    rst = 1;
    tick(); chk("boot_e0_req", imem.imem_req, 1'b0);
    tick(); chk("boot_e1_req", imem.imem_req, 1'b0);
    tick(); chk("boot_e2_req", imem.imem_req, 1'b1);
    chk("boot_addr", imem.imem_addr, 32'h0);
    tick();
    chk("first_valid", instr_valid, 1'b1);
    chk("first_instr", instr, W_ADDI);
    chk("first_opcode", opcode, 6'b001000);
    chk("first_pc", pc, 32'h0);
    chk("first_pc4", pc_plus4, 32'h4);

    // sequential advance into a 3-wait-state fetch
    dir_word = W_J10; dir_wait = 3; inc_pc = 1;
    tick();
    inc_pc = 0;
    for (int k = 0; k < 4; k++) begin
      chk("wait_req", imem.imem_req, 1'b1);
      chk("wait_addr", imem.imem_addr, 32'h4);
      chk("wait_instr", instr, NOP);
      chk("wait_valid", instr_valid, 1'b0);
      if (k < 3) tick();
    end
    tick();
    chk("wait_loaded_valid", instr_valid, 1'b1);
    chk("wait_loaded_instr", instr, W_J10);

    adv(W_BEQ, 1, 0, 0, 0, 32'h0,    32'h40,   "j_0x10");
    adv(W_J10, 0, 1, 0, 1, 32'h0,    32'h3C,   "beq_taken");
    adv(W_BEQ, 1, 0, 0, 0, 32'h0,    32'h40,   "j_back");
    adv(W_JR,  0, 1, 0, 0, 32'h0,    32'h44,   "beq_not_taken");
    adv(W_STL, 1, 0, 0, 0, 32'h1003, 32'h1000, "jr");
    chk("jr_misalign", misalign, 1'b1);

    // stall opcode: inc_pc held high must not advance
    inc_pc = 1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("stall_pc", pc, 32'h1000);
      chk("stall_valid", instr_valid, 1'b1);
      chk("stall_req", imem.imem_req, 1'b0);
      chk("stall_mis", misalign, 1'b1);
    end
    inc_pc = 0;

    // reset asserted in the very cycle the ack arrives
    rst = 0; tick(); rst = 1;
    dir_word = 32'h1234_5678; dir_wait = 0;
    tick(); tick(); tick();
    chk("rfetch_req", imem.imem_req, 1'b1);
    rst = 0;
    tick();
    chk("rfetch_instr", instr, 32'hFC00_0000);
    chk("rfetch_pc", pc, RPC);
    chk("rfetch_req0", imem.imem_req, 1'b0);
    chk("rfetch_valid", instr_valid, 1'b0);
    chk("rfetch_mis", misalign, 1'b0);

    // random traffic against the model
    rst = 1; rand_mode = 1;
    for (int c = 0; c < 4000; c++) begin
      tick();
      rst     = ($urandom_range(0, 149) != 0);
      inc_pc  = $urandom_range(0, 1);
      jump    = ($urandom_range(0, 3) == 0);
      beq     = $urandom_range(0, 1);
      bne     = $urandom_range(0, 1);
      zero    = $urandom_range(0, 1);
      rs_data = $urandom;
      if ($urandom_range(0, 1) == 1) rs_data[1:0] = 2'b00;
    end
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch and PC sequencer; sits directly upstream of the control decoder.
- Holds the PC and issues a req/ack read to instruction memory.
- Latches the returned word into an instruction register (IR), which drives the decoder's opcode and funct inputs.
- Consumes the decoder's jump/branch/inc_pc outputs and the ALU zero flag to compute the next PC.

Parameters:
- ADDR_W, 32, PC and imem address width (minimum 28).
- RESET_PC, 0, PC value loaded on reset; must be word-aligned.
- NOP_WORD, 32'hFC000000, IR value while no instruction is valid (opcode 6'b111111 = no-op).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-low.
- imem_req  out  1  fetch request; held high until ack.
- imem_addr  out  ADDR_W  fetch address; equals pc, stable while imem_req is high.
- imem_ack  in  1  read data valid this cycle.
- imem_rdata  in  32  instruction word.
- inc_pc  in  1  decoder advance strobe.
- jump  in  1  decoder jump (J, JAL, JR).
- branch_on_eq  in  1  decoder BEQ.
- branch_on_neq  in  1  decoder BNE.
- zero  in  1  ALU zero flag.
- rs_data  in  ADDR_W  register rs value, used as the JR target.
- instr  out  32  IR contents.
- opcode  out  6  instr[31:26].
- funct  out  6  instr[5:0].
- pc  out  ADDR_W  address of the instruction in IR.
- pc_plus4  out  ADDR_W  pc+4; JAL link value.
- instr_valid  out  1  IR holds a fetched instruction.
- misalign  out  1  sticky: a JR target had nonzero bits [1:0].

Behaviour:
- Reset (rst==0 at posedge): state=IDLE, pc=RESET_PC, IR=NOP_WORD, imem_req=0, instr_valid=0, misalign=0.
  - An in-flight fetch is abandoned; an ack arriving in the reset cycle is ignored.
- States:
  - IDLE: one cycle after reset release, then -> FETCH.
  - FETCH: imem_req=1, imem_addr=pc. On imem_ack at a posedge: IR<=imem_rdata, -> HOLD. Otherwise remain in FETCH; no timeout.
  - HOLD: imem_req=0, instr_valid=1. When inc_pc==1 at a posedge: pc<=next_pc, IR<=NOP_WORD, instr_valid<=0, -> FETCH. When inc_pc==0: hold.
- Latency: with a zero-wait memory (ack in the first FETCH cycle), instr_valid rises 1 cycle after entering FETCH. The first request is asserted 2 cycles after the posedge at which rst is sampled high.
- Stall: if IR opcode==6'b000110, inc_pc is ignored in HOLD (defensive; the decoder also holds inc_pc low).
- imem_ack outside FETCH is ignored. inc_pc outside HOLD is ignored.
- next_pc, evaluated combinationally in HOLD. Priority: jump > branch > sequential.
  - jump and IR opcode==0 (JR): {rs_data[ADDR_W-1:2],2'b00}. Set misalign if rs_data[1:0]!=0.
  - jump, other opcode (J/JAL): {pc_plus4[ADDR_W-1:28], IR[25:0], 2'b00}.
  - taken = (branch_on_eq&zero)|(branch_on_neq&~zero): pc_plus4 + (sign_extend(IR[15:0])<<2).
  - else: pc_plus4.
- All PC arithmetic is modulo 2^ADDR_W; wrap-around at the top of the address space is permitted and silent.
- misalign is cleared only by reset.
- pc_plus4, opcode, funct are combinational from the pc and IR registers.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode constants: OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_STALL, OP_NOP;
  - NOP_WORD;
  - the fetch state enum {IDLE, FETCH, HOLD}.
- One sub-module: next_pc_calc, purely combinational. It takes pc, IR, the control signals, zero and rs_data, and returns next_pc and a misalign pulse.

Test Plan:
- Reset then zero-wait memory returning 0x20010005 at addr 0 -> imem_req at cycle 2, instr_valid the next cycle, opcode=6'b001000, pc=0, pc_plus4=4; inc_pc pulse -> imem_addr=4.
- Memory inserting 3 wait cycles -> imem_req and imem_addr held stable for 4 cycles; IR loaded only on ack.
- BEQ at pc=0x40, IR[15:0]=0xFFFE, branch_on_eq=1, zero=1, inc_pc -> next imem_addr=0x3C. Same with zero=0 -> 0x44.
- J with target 0x0000010 at pc=0x40 -> next imem_addr=0x40. JR with rs_data=0x1003 -> imem_addr=0x1000 and misalign=1, staying 1 until reset.
- IR opcode 6'b000110 (stall) with inc_pc=1 held for 5 cycles -> pc unchanged, instr_valid stays 1, no imem_req.
- rst low during FETCH with ack in the same cycle -> IR=0xFC000000, pc=RESET_PC, imem_req=0, instr_valid=0.
